// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with fixed LATENCY ack.
// One word request at a time; result registered on RESP entry.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic          a_bad;
  logic [AW-1:0] a_idx;
  logic          mem_we;
  logic [31:0]   rdata_d;
  logic          err_d;

  assign accept = (state_q == IDLE) && req_i;

  // Array access must never fire while reset is held.
  assign enter_resp = rst_i
                   && (state_d == RESP)
                   && (state_q != RESP);

  // With LATENCY=1 the access shares the accept edge,
  // so the request comes straight from the inputs.
  assign a_we    = (state_q == IDLE) ? we_i    : we_q;
  assign a_addr  = (state_q == IDLE) ? addr_i  : addr_q;
  assign a_wdata = (state_q == IDLE) ? wdata_i : wdata_q;

  assign a_bad = (a_addr[1:0] != 2'b00)
              || (a_addr[31:2] >= 30'(DEPTH));
  assign a_idx = a_addr[AW+1:2];

  assign ready_o = (state_q == IDLE);
  assign ack_o   = (state_q == RESP);
  assign busy_o  = (state_q != IDLE);

  // Next-state and countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Decode the access: error, write or read.
  always_comb begin
    mem_we  = 1'b0;
    rdata_d = 32'd0;
    err_d   = 1'b0;
    unique case (1'b1)
      a_bad: begin
        err_d = 1'b1;
      end
      (!a_bad && a_we): begin
        mem_we = 1'b1;
      end
      (!a_bad && !a_we): begin
        rdata_d = mem[a_idx];
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  // Control state, request latch and response registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_o <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (enter_resp) begin
        rdata_o <= rdata_d;
        err_o   <= err_d;
      end
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (enter_resp && mem_we) begin
      mem[a_idx] <= a_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: three responders (LATENCY 3, 1, 15)
// checked against an array model of the storage.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ready [3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];

  int lat_tab [3] = '{3, 1, 15};

  int checks = 0;
  int passes = 0;

  logic [31:0] mm [3][256];
  bit          kn [3][256];

  dmem_responder #(.DEPTH(256), .LATENCY(3)) u0 (
    .clk_i(clk), .rst_i(rst_n),
    .req_i(req[0]), .we_i(we[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]),
    .ready_o(ready[0]), .ack_o(ack[0]),
    .rdata_o(rdata[0]), .err_o(err[0]),
    .busy_o(busy[0])
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u1 (
    .clk_i(clk), .rst_i(rst_n),
    .req_i(req[1]), .we_i(we[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]),
    .ready_o(ready[1]), .ack_o(ack[1]),
    .rdata_o(rdata[1]), .err_o(err[1]),
    .busy_o(busy[1])
  );

  dmem_responder #(.DEPTH(256), .LATENCY(15)) u2 (
    .clk_i(clk), .rst_i(rst_n),
    .req_i(req[2]), .we_i(we[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]),
    .ready_o(ready[2]), .ack_o(ack[2]),
    .rdata_o(rdata[2]), .err_o(err[2]),
    .busy_o(busy[2])
  );

  // Reference: word array, error if misaligned or beyond 256 words.
  function automatic void ref_access(
    input  int          k,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic [31:0] rd,
    output logic        e,
    output bit          known
  );
    int idx;
    e     = (a % 4 != 0) || ((a >> 2) >= 32'd256);
    rd    = 32'd0;
    known = 1'b1;
    if (!e) begin
      idx = int'(a >> 2);
      if (w) begin
        mm[k][idx] = d;
        kn[k][idx] = 1'b1;
      end else begin
        rd    = mm[k][idx];
        known = kn[k][idx];
      end
    end
  endfunction

  // Called at a negedge with instance k idle; returns at the
  // negedge of the first idle cycle after the ack.
  task automatic run_txn(
    input  int          k,
    input  logic        w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          lat,
    output logic [31:0] rd,
    output logic        e,
    output bit          bad,
    output bit          tail_bad
  );
    req[k]   = 1'b1;
    we[k]    = w;
    addr[k]  = a;
    wdata[k] = d;
    lat      = -1;
    rd       = 32'hx;
    e        = 1'bx;
    bad      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req[k] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (busy[k] !== 1'b1 || ready[k] !== 1'b0) bad = 1'b1;
      if (ack[k] === 1'b1) begin
        lat = c;
        rd  = rdata[k];
        e   = err[k];
        break;
      end
    end
    @(negedge clk);
    tail_bad = (ack[k] !== 1'b0) || (ready[k] !== 1'b1)
            || (busy[k] !== 1'b0);
  endtask

  task automatic test_reset;
    int bad;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k]   = 1'b0;
      we[k]    = 1'b0;
      addr[k]  = 32'd0;
      wdata[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({ready[k], ack[k], busy[k], err[k]} !== 4'b1000
          || rdata[k] !== 32'd0)
        $display("FAIL reset_state[%0d]: rdy=%b ack=%b busy=%b err=%b rdata=%h, expected 1 0 0 0 0",
                 k, ready[k], ack[k], busy[k], err[k], rdata[k]);
      else passes++;
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (ack[k] !== 1'b0 || ready[k] !== 1'b1 || busy[k] !== 1'b0)
          bad++;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL idle_20: %0d bad samples, expected 0", bad);
    else passes++;
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd, xrd; logic e, xe; bit b, t, kw;
    run_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, rd, e, b, t);
    ref_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, xrd, xe, kw);
    checks++;
    if (lat !== 3 || e !== 1'b0 || b || t)
      $display("FAIL wr_10: lat=%0d err=%b busy_bad=%b tail_bad=%b, expected 3 0 0 0",
               lat, e, b, t);
    else passes++;
    run_txn(0, 1'b0, 32'h10, 32'd0, lat, rd, e, b, t);
    ref_access(0, 1'b0, 32'h10, 32'd0, xrd, xe, kw);
    checks++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF || e !== 1'b0 || b || t)
      $display("FAIL rd_10: lat=%0d rdata=%h err=%b, expected 3 deadbeef 0",
               lat, rd, e);
    else passes++;
  endtask

  task automatic test_errors;
    int lat; logic [31:0] rd, xrd, v, w; logic e, xe; bit b, t, kw;
    run_txn(0, 1'b0, 32'h12, 32'd0, lat, rd, e, b, t);
    ref_access(0, 1'b0, 32'h12, 32'd0, xrd, xe, kw);
    checks++;
    if (lat !== 3 || e !== 1'b1 || rd !== 32'd0 || b || t)
      $display("FAIL misaligned_12: lat=%0d err=%b rdata=%h, expected 3 1 0",
               lat, e, rd);
    else passes++;
    v = $urandom;
    w = ~v;
    run_txn(0, 1'b1, 32'h0, v, lat, rd, e, b, t);
    ref_access(0, 1'b1, 32'h0, v, xrd, xe, kw);
    run_txn(0, 1'b1, 32'h400, w, lat, rd, e, b, t);
    ref_access(0, 1'b1, 32'h400, w, xrd, xe, kw);
    checks++;
    if (lat !== 3 || e !== 1'b1 || rd !== 32'd0)
      $display("FAIL range_400: lat=%0d err=%b rdata=%h, expected 3 1 0",
               lat, e, rd);
    else passes++;
    run_txn(0, 1'b0, 32'h0, 32'd0, lat, rd, e, b, t);
    ref_access(0, 1'b0, 32'h0, 32'd0, xrd, xe, kw);
    checks++;
    if (rd !== v || e !== 1'b0)
      $display("FAIL rd_0_after_bad: rdata=%h err=%b, expected %h 0",
               rd, e, v);
    else passes++;
  endtask

  task automatic test_held;
    int lat; logic [31:0] rd, xrd, v4, v8, r1, r3;
    logic e, xe; bit b, t, kw;
    logic [3:0] rs, as, bs;
    v4 = $urandom;
    v8 = $urandom;
    run_txn(1, 1'b1, 32'h4, v4, lat, rd, e, b, t);
    ref_access(1, 1'b1, 32'h4, v4, xrd, xe, kw);
    checks++;
    if (lat !== 1 || e !== 1'b0 || b || t)
      $display("FAIL lat1_wr: lat=%0d err=%b, expected 1 0", lat, e);
    else passes++;
    run_txn(1, 1'b1, 32'h8, v8, lat, rd, e, b, t);
    ref_access(1, 1'b1, 32'h8, v8, xrd, xe, kw);
    req[1]  = 1'b1;
    we[1]   = 1'b0;
    addr[1] = 32'h4;
    rs[3] = ready[1]; as[3] = ack[1]; bs[3] = busy[1];
    @(negedge clk);
    rs[2] = ready[1]; as[2] = ack[1]; bs[2] = busy[1];
    r1 = rdata[1];
    addr[1] = 32'h8;
    @(negedge clk);
    rs[1] = ready[1]; as[1] = ack[1]; bs[1] = busy[1];
    @(negedge clk);
    rs[0] = ready[1]; as[0] = ack[1]; bs[0] = busy[1];
    r3 = rdata[1];
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (rs !== 4'b1010)
      $display("FAIL held_ready: got %b, expected 1010", rs);
    else passes++;
    checks++;
    if (as !== 4'b0101 || bs !== 4'b0101)
      $display("FAIL held_ack_busy: ack=%b busy=%b, expected 0101 0101",
               as, bs);
    else passes++;
    checks++;
    if (r1 !== v4 || r3 !== v8)
      $display("FAIL held_rdata: got %h %h, expected %h %h",
               r1, r3, v4, v8);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int lat, bad; logic [31:0] rd, xrd, p, q;
    logic e, xe; bit b, t, kw;
    p = $urandom;
    q = 32'h1234_5678;
    if (p == q) p = ~p;
    run_txn(0, 1'b1, 32'h20, p, lat, rd, e, b, t);
    ref_access(0, 1'b1, 32'h20, p, xrd, xe, kw);
    req[0]   = 1'b1;
    we[0]    = 1'b1;
    addr[0]  = 32'h20;
    wdata[0] = q;
    @(posedge clk);
    @(negedge clk);
    req[0] = 1'b0;
    checks++;
    if (busy[0] !== 1'b1)
      $display("FAIL mid_wait_busy: got %b, expected 1", busy[0]);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL async_reset: rdy=%b busy=%b, expected 1 0",
               ready[0], busy[0]);
    else passes++;
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[0] !== 1'b0 || ready[0] !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0)
      $display("FAIL mid_no_ack: %0d bad samples, expected 0", bad);
    else passes++;
    run_txn(0, 1'b0, 32'h20, 32'd0, lat, rd, e, b, t);
    ref_access(0, 1'b0, 32'h20, 32'd0, xrd, xe, kw);
    checks++;
    if (rd !== p || e !== 1'b0)
      $display("FAIL mid_rd_20: rdata=%h err=%b, expected %h 0",
               rd, e, p);
    else passes++;
  endtask

  task automatic test_lat15;
    int lat; logic [31:0] rd, xrd, v; logic e, xe; bit b, t, kw;
    v = $urandom;
    run_txn(2, 1'b1, 32'h40, v, lat, rd, e, b, t);
    ref_access(2, 1'b1, 32'h40, v, xrd, xe, kw);
    run_txn(2, 1'b0, 32'h40, 32'd0, lat, rd, e, b, t);
    ref_access(2, 1'b0, 32'h40, 32'd0, xrd, xe, kw);
    checks++;
    if (lat !== 15 || b || t)
      $display("FAIL lat15_timing: lat=%0d busy_bad=%b tail_bad=%b, expected 15 0 0",
               lat, b, t);
    else passes++;
    checks++;
    if (rd !== v || e !== 1'b0)
      $display("FAIL lat15_rdata: rdata=%h err=%b, expected %h 0",
               rd, e, v);
    else passes++;
  endtask

  task automatic test_random;
    int lat, kind; logic [31:0] a, d, rd, xrd;
    logic w, e, xe; bit b, t, kw;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 12; n++) begin
        kind = $urandom_range(0, 9);
        if (kind == 0)
          a = 32'($urandom_range(0, 255)) * 4
            + 32'($urandom_range(1, 3));
        else if (kind == 1)
          a = ($urandom & 32'hFFFF_FFFC) | 32'h400;
        else
          a = 32'($urandom_range(0, 15)) * 4;
        w = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
        d = $urandom;
        run_txn(k, w, a, d, lat, rd, e, b, t);
        ref_access(k, w, a, d, xrd, xe, kw);
        checks++;
        if (lat !== lat_tab[k] || b || t)
          $display("FAIL rnd_timing[%0d.%0d]: lat=%0d busy_bad=%b tail_bad=%b, expected %0d 0 0",
                   k, n, lat, b, t, lat_tab[k]);
        else passes++;
        checks++;
        if (e !== xe)
          $display("FAIL rnd_err[%0d.%0d] a=%h: got %b, expected %b",
                   k, n, a, e, xe);
        else passes++;
        if (kw) begin
          checks++;
          if (rd !== xrd)
            $display("FAIL rnd_rdata[%0d.%0d] a=%h: got %h, expected %h",
                     k, n, a, rd, xrd);
          else passes++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_held();
    test_reset_mid();
    test_lat15();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
